// File: rtl/result_mem_pkg.sv
// Shared types and defaults for the result memory controller and its arbiter.
package result_mem_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on contention the side that did not win last time is granted.
module rr_arb2
  import result_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic xfer,
  output logic gnt_wr,
  output logic gnt_rd
);

  grant_t last_grant;

  always_comb begin
    gnt_wr = req_wr && (!req_rd || (last_grant == READ));
    gnt_rd = req_rd && (!req_wr || (last_grant == WRITE));
  end

  // Reset to READ so the first contended grant goes to the write side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= READ;
    end else if (xfer) begin
      last_grant <= gnt_wr ? WRITE : READ;
    end
  end

endmodule

// File: rtl/result_mem_ctrl.sv
// Shares the result memory between the compute writer and the readout reader, sequences the
// registered one-cycle memory read, returns data on a valid/ready channel and runs a clear sweep.
module result_mem_ctrl
  import result_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  // Handshakes: a request transfers on a cycle where its valid and ready are both high; a
  // response transfers on a cycle where rsp_valid and rsp_ready are both high. Ready is only
  // offered in IDLE with no clear pending, and only to the arbiter's granted side.

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              clr_done_q, clr_done_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic open_q;
  logic gnt_wr, gnt_rd;

  assign open_q   = (state_q == IDLE) && !clr_req;
  assign wr_ready = open_q && gnt_wr;
  assign rd_ready = open_q && gnt_rd;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_wr (wr_valid),
    .req_rd (rd_valid),
    .xfer   (wr_ready || rd_ready),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    clr_done_d  = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          cnt_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b1;
          state_d = CLEAR;
        end else if (wr_ready) begin
          addr_d  = wr_addr;
          wdata_d = wr_data;
          we_d    = 1'b1;
          state_d = ISSUE;
        end else if (rd_ready) begin
          addr_d  = rd_addr;
          we_d    = 1'b0;
          state_d = ISSUE;
        end
      end
      // mem_we distinguishes a write from a read while the memory samples.
      ISSUE: begin
        if (we_q) begin
          we_d    = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_data_d  = mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_CNT) begin
          we_d       = 1'b0;
          clr_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d  = cnt_q + (ADDR_W + 1)'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      clr_done_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      clr_done_q  <= clr_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign clr_done  = clr_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/result_mem_ctrl.md
Name: result_mem_ctrl

Overview:
Controller that shares the 16x16 result memory between two requesters: the compute datapath, which writes results, and the readout/display logic, which reads them. It arbitrates round-robin, sequences the memory's registered one-cycle read, returns read data over a valid/ready handshake, and provides a clear sweep that zeroes every word. It sits between the requesters and the memory's clk/addr/data_in/write_en/data_out interface.

Parameters:
ADDR_W, 4, memory address width; DEPTH = 2**ADDR_W words
DATA_W, 16, memory word width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
clr_req  input  1  level request to zero all DEPTH words
clr_done  output  1  one-cycle pulse after the last clear write
wr_valid  input  1  write request valid
wr_ready  output  1  write request accepted this cycle
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_valid  input  1  read request valid
rd_ready  output  1  read request accepted this cycle
rd_addr  input  ADDR_W  read address
rsp_valid  output  1  read response valid
rsp_ready  input  1  read response consumed
rsp_data  output  DATA_W  read response data
mem_addr  output  ADDR_W  to memory addr, registered
mem_wdata  output  DATA_W  to memory data_in, registered
mem_we  output  1  to memory write_en, registered
mem_rdata  input  DATA_W  from memory data_out
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset: state=IDLE; mem_addr=0, mem_wdata=0, mem_we=0, rsp_valid=0, rsp_data=0, clr_done=0, clear counter=0, last_grant=READ, so the first contended grant goes to the write side.
- A reset asserted mid-operation aborts the operation immediately. Any pending response is dropped, and mem_we falls asynchronously.
- States: IDLE, ISSUE, CAPTURE, RESP, CLEAR.
- IDLE, grant priority: clr_req, then round-robin between wr_valid and rd_valid. With both valid, the side not in last_grant wins. With one valid, that side wins.
- wr_ready and rd_ready are combinational and high only in IDLE, only for the granted side, and never when clr_req=1. A transfer occurs when valid and ready are both high.
- Write accepted: register mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1; last_grant=WRITE; go to ISSUE.
- Read accepted: register mem_addr=rd_addr, mem_we=0; last_grant=READ; go to ISSUE.
- ISSUE: the memory samples on the edge that ends this cycle. For a write, mem_we clears and the state returns to IDLE (2 cycles per write). For a read, go to CAPTURE.
- CAPTURE: mem_rdata is valid. Register rsp_data=mem_rdata, set rsp_valid=1, go to RESP.
- Read latency: accept in cycle N, rsp_valid high in cycle N+3.
- RESP: hold rsp_valid and rsp_data stable until rsp_ready. On that edge, clear rsp_valid and return to IDLE. No new request is accepted while in RESP, so responses never reorder.
- Clear entry: clr_req seen in IDLE loads counter=0, mem_addr=0, mem_wdata=0, mem_we=1, and goes to CLEAR.
- CLEAR: one write per cycle. The counter and mem_addr increment through DEPTH-1. After the write to DEPTH-1, mem_we=0, clr_done pulses for 1 cycle, and the state returns to IDLE.
- The counter is ADDR_W+1 bits wide, so reaching the terminal count does not depend on wrap-around.
- clr_req is ignored outside IDLE and is re-sampled there. A held clr_req restarts the sweep.
- Requests held valid during busy stay pending; they are neither dropped nor auto-accepted.
- Address arithmetic is unsigned with no wrap-around other than the counter's terminal detect.

Decomposition:
- Shared package result_mem_pkg: state enum (IDLE, ISSUE, CAPTURE, RESP, CLEAR), grant enum (WRITE, READ), ADDR_W/DATA_W defaults.
- Sub-module rr_arb2: two-input round-robin arbiter with a last_grant register, updated only on a transfer.
- The memory itself stays external. The bench instantiates result_memory behind this block.

Test Plan:
- Write then read: write addr 3 = 16'hBEEF, then read addr 3 -> rsp_data=16'hBEEF, rsp_valid 3 cycles after rd_ready.
- Contention: wr_valid and rd_valid both held high from reset -> grants alternate W,R,W,R. The first grant is write; no side starves.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, busy=1, no ready asserted. The response completes on the rsp_ready cycle.
- Clear: fill all 16 words with 16'hFFFF, pulse clr_req -> 16 consecutive mem_we cycles at addresses 0..15 and clr_done 16 cycles after entry. Subsequent reads of every address return 0.
- Clear priority: clr_req, wr_valid and rd_valid all asserted in IDLE -> CLEAR is entered, wr_ready=rd_ready=0 throughout, and the requests are served afterwards.
- Async reset mid-read: assert rst in CAPTURE -> immediately mem_we=0, rsp_valid=0, busy=0. After release, a fresh read at addr 7 returns the stored value.
